// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and helpers for the multi-port register file.
package regfile_pkg;
    localparam int RESET_ZERO  = 0;
    localparam int RESET_INDEX = 1;
    localparam int MAX_RD      = 4;

    function automatic int clog2(input int n);
        int r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) r++;
        return r;
    endfunction
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending-write bits, busy count and
// double-reservation error flag.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    output logic [ADDR_W:0]          pend_cnt_o,
    output logic                     rsv_err_o
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = clog2(DEPTH) + 1;

    logic [DEPTH-1:0] busy_q, busy_d;
    logic [CNT_W-1:0] pend_cnt_q, pend_cnt_d;
    logic             rsv_err_q, rsv_err_d;
    logic             wr_eff, rsv_eff, same, inc, dec;

    assign wr_eff  = wr_en_i && !(ZERO_REG != 0 && wr_addr_i == '0);
    assign rsv_eff = rsv_en_i && !(ZERO_REG != 0 && rsv_addr_i == '0);
    assign same    = wr_eff && wr_addr_i == rsv_addr_i;
    // A same-address write+reserve on a busy register hands it to the new producer: net 0
    assign inc     = rsv_eff && !busy_q[rsv_addr_i];
    assign dec     = wr_eff && busy_q[wr_addr_i] && !(rsv_eff && wr_addr_i == rsv_addr_i);

    always_comb begin
        busy_d = busy_q;
        if (wr_eff) busy_d[wr_addr_i] = 1'b0;
        if (rsv_eff) busy_d[rsv_addr_i] = 1'b1;
        pend_cnt_d = pend_cnt_q + CNT_W'(inc) - CNT_W'(dec);
        rsv_err_d  = rsv_eff && busy_q[rsv_addr_i] && !same;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            busy_q     <= '0;
            pend_cnt_q <= '0;
            rsv_err_q  <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
            rsv_err_q  <= rsv_err_d;
        end
    end

    assign pend_cnt_o = pend_cnt_q;
    assign rsv_err_o  = rsv_err_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
        logic [ADDR_W-1:0] a;
        assign a = rd_addr_i[k*ADDR_W +: ADDR_W];
        assign rd_busy_o[k] = busy_q[a] && !(BYPASS != 0 && wr_en_i && wr_addr_i == a)
                              && !(ZERO_REG != 0 && a == '0);
    end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with write bypass, hardwired zero
// register, selectable reset contents and a pending-write scoreboard.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int RESET_MODE = 0
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr_i,
    output logic [NUM_RD*DATA_W-1:0] rd_data_o,
    output logic [NUM_RD-1:0]        rd_busy_o,
    input  logic                     wr_en_i,
    input  logic [ADDR_W-1:0]        wr_addr_i,
    input  logic [DATA_W-1:0]        wr_data_i,
    input  logic                     rsv_en_i,
    input  logic [ADDR_W-1:0]        rsv_addr_i,
    output logic [ADDR_W:0]          pend_cnt_o,
    output logic                     rsv_err_o
);
    localparam int DEPTH = 1 << ADDR_W;

    if (NUM_RD < 1 || NUM_RD > MAX_RD) begin : g_bad_num_rd
        $error("regfile_mp: NUM_RD out of range");
    end
    if (RESET_MODE != RESET_ZERO && RESET_MODE != RESET_INDEX) begin : g_bad_reset_mode
        $error("regfile_mp: unsupported RESET_MODE");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_eff;

    assign wr_eff = wr_en_i && !(ZERO_REG != 0 && wr_addr_i == '0);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= (RESET_MODE == RESET_INDEX) ? DATA_W'(i) : '0;
        end else if (wr_eff) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr_i[k*ADDR_W +: ADDR_W];
        assign rd_data_o[k*DATA_W +: DATA_W] =
            (ZERO_REG != 0 && a == '0)                   ? '0        :
            (BYPASS != 0 && wr_en_i && wr_addr_i == a)   ? wr_data_i :
                                                           mem_q[a];
    end

    regfile_scoreboard #(
        .ADDR_W  (ADDR_W),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(ZERO_REG),
        .BYPASS  (BYPASS)
    ) u_sb (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .rd_addr_i (rd_addr_i),
        .rd_busy_o (rd_busy_o),
        .wr_en_i   (wr_en_i),
        .wr_addr_i (wr_addr_i),
        .rsv_en_i  (rsv_en_i),
        .rsv_addr_i(rsv_addr_i),
        .pend_cnt_o(pend_cnt_o),
        .rsv_err_o (rsv_err_o)
    );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed vector table driving two register files in lockstep,
// one bypassing with zero reset and one non-bypassing with index reset.
module tb_regfile_mp;
    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  rd_addr;
    logic        wr_en, rsv_en;
    logic [4:0]  wr_addr, rsv_addr;
    logic [31:0] wr_data;
    logic [63:0] rd_data_a, rd_data_b;
    logic [1:0]  rd_busy_a, rd_busy_b;
    logic [5:0]  pend_cnt_a, pend_cnt_b;
    logic        rsv_err_a, rsv_err_b;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1), .RESET_MODE(0)) u_a (
        .clk_i(clk), .reset_i(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data_a),
        .rd_busy_o(rd_busy_a), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .pend_cnt_o(pend_cnt_a), .rsv_err_o(rsv_err_a)
    );

    regfile_mp #(.BYPASS(0), .RESET_MODE(1)) u_b (
        .clk_i(clk), .reset_i(reset), .rd_addr_i(rd_addr), .rd_data_o(rd_data_b),
        .rd_busy_o(rd_busy_b), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr), .pend_cnt_o(pend_cnt_b), .rsv_err_o(rsv_err_b)
    );

    typedef struct packed {
        logic [31:0] rst, we, wa, wd, re, ra, r0, r1;
        logic [31:0] a0, a1, ab, b0, b1, bb, cnt, err;
    } vec_t;

    localparam int N = 19;
    vec_t tv [N];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re, input logic [4:0] ra, input logic [4:0] r0, input logic [4:0] r1);
        reset = r; wr_en = we; wr_addr = wa; wr_data = wd;
        rsv_en = re; rsv_addr = ra; rd_addr = {r1, r0};
    endtask

    initial begin
        // fields: rst we wa wd re ra r0 r1 | a0 a1 abusy b0 b1 bbusy | cnt err (after edge)
        tv[0]  = '{0, 1, 5, 'hDEADBEEF, 0, 0, 5, 7, 'hDEADBEEF, 0, 0, 5, 7, 0, 0, 0};
        tv[1]  = '{0, 0, 0, 0, 0, 0, 5, 0, 'hDEADBEEF, 0, 0, 'hDEADBEEF, 0, 0, 0, 0};
        tv[2]  = '{0, 1, 0, 'h1234, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[3]  = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        tv[4]  = '{0, 0, 0, 0, 0, 0, 0, 5, 0, 'hDEADBEEF, 0, 0, 'hDEADBEEF, 0, 0, 0};
        tv[5]  = '{0, 0, 0, 0, 1, 9, 9, 9, 0, 0, 0, 9, 9, 0, 1, 0};
        tv[6]  = '{0, 1, 9, 'h99, 0, 0, 9, 8, 'h99, 0, 0, 9, 8, 1, 0, 0};
        tv[7]  = '{0, 0, 0, 0, 0, 0, 9, 9, 'h99, 'h99, 0, 'h99, 'h99, 0, 0, 0};
        tv[8]  = '{0, 0, 0, 0, 1, 3, 3, 9, 0, 'h99, 0, 3, 'h99, 0, 1, 0};
        tv[9]  = '{0, 1, 3, 'hAA, 1, 3, 3, 3, 'hAA, 'hAA, 0, 3, 3, 3, 1, 0};
        tv[10] = '{0, 0, 0, 0, 1, 3, 3, 0, 'hAA, 0, 1, 'hAA, 0, 1, 1, 1};
        tv[11] = '{0, 0, 0, 0, 0, 0, 3, 3, 'hAA, 'hAA, 3, 'hAA, 'hAA, 3, 1, 0};
        tv[12] = '{0, 1, 3, 'h33, 1, 4, 3, 4, 'h33, 0, 0, 'hAA, 4, 1, 1, 0};
        tv[13] = '{0, 0, 0, 0, 0, 0, 3, 4, 'h33, 0, 2, 'h33, 4, 2, 1, 0};
        tv[14] = '{0, 0, 0, 0, 1, 1, 1, 2, 0, 0, 0, 1, 2, 0, 2, 0};
        tv[15] = '{0, 0, 0, 0, 1, 2, 1, 2, 0, 0, 1, 1, 2, 1, 3, 0};
        tv[16] = '{0, 0, 0, 0, 1, 3, 1, 2, 0, 0, 3, 1, 2, 3, 4, 0};
        tv[17] = '{1, 1, 2, 'h5555, 1, 1, 2, 4, 'h5555, 0, 2, 2, 4, 3, 0, 0};
        tv[18] = '{0, 0, 0, 0, 0, 0, 2, 3, 0, 0, 0, 2, 3, 0, 0, 0};

        drive(1, 0, 0, 0, 0, 0, 7, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst a rd7", rd_data_a[31:0], 32'h0);
        chk("rst b rd7", rd_data_b[31:0], 32'h7);
        chk("rst cnt", 32'(pend_cnt_a), 32'h0);
        chk("rst err", 32'(rsv_err_a), 32'h0);
        chk("rst busy", 32'(rd_busy_a), 32'h0);

        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            drive(tv[i].rst[0], tv[i].we[0], tv[i].wa[4:0], tv[i].wd,
                  tv[i].re[0], tv[i].ra[4:0], tv[i].r0[4:0], tv[i].r1[4:0]);
            #1;
            chk($sformatf("v%0d a d0", i), rd_data_a[31:0], tv[i].a0);
            chk($sformatf("v%0d a d1", i), rd_data_a[63:32], tv[i].a1);
            chk($sformatf("v%0d a busy", i), 32'(rd_busy_a), tv[i].ab);
            chk($sformatf("v%0d b d0", i), rd_data_b[31:0], tv[i].b0);
            chk($sformatf("v%0d b d1", i), rd_data_b[63:32], tv[i].b1);
            chk($sformatf("v%0d b busy", i), 32'(rd_busy_b), tv[i].bb);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d a cnt", i), 32'(pend_cnt_a), tv[i].cnt);
            chk($sformatf("v%0d a err", i), 32'(rsv_err_a), tv[i].err);
            chk($sformatf("v%0d b cnt", i), 32'(pend_cnt_b), tv[i].cnt);
            chk($sformatf("v%0d b err", i), 32'(rsv_err_b), tv[i].err);
        end

        // Fill every reservable register, then over-reserve and drain by writeback
        for (int r = 0; r < 32; r++) begin
            @(negedge clk);
            drive(0, 0, 0, 0, 1, 5'(r), 0, 0);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 31, 31, 0);
        #1;
        chk("full cnt", 32'(pend_cnt_a), 32'd31);
        chk("full busy", 32'(rd_busy_a), 32'h1);
        @(posedge clk);
        #1;
        chk("over err", 32'(rsv_err_a), 32'h1);
        chk("over cnt", 32'(pend_cnt_a), 32'd31);
        for (int r = 1; r < 32; r++) begin
            @(negedge clk);
            drive(0, 1, 5'(r), 32'(r), 0, 0, 31, 30);
        end
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 31, 30);
        #1;
        chk("drain cnt", 32'(pend_cnt_a), 32'h0);
        chk("drain err", 32'(rsv_err_a), 32'h0);
        chk("drain busy", 32'(rd_busy_b), 32'h0);
        chk("drain a d0", rd_data_a[31:0], 32'd31);
        chk("drain b d1", rd_data_b[63:32], 32'd30);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the MIPS datapath. Clocked writes, combinational reads.
- Adds write-to-read bypass, a hardwired zero register, selectable reset contents, and a per-register pending-write scoreboard.
- Decode uses the scoreboard to stall on operands whose producer (load/multi-cycle op) has not yet written back.
- Sits between decode (read ports, reservations) and writeback (write port).

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports
- RESET_MODE, 0, 0 = registers reset to 0; 1 = register i resets to i (zero-extended)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port k at bits [k*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data; port k at bits [k*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  port k operand has a pending write not yet satisfied
- wr_en  in  1  write enable
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rsv_en  in  1  reserve (mark pending) a destination register
- rsv_addr  in  ADDR_W  register to reserve
- pend_cnt  out  ADDR_W+1  number of registers currently marked busy
- rsv_err  out  1  registered; pulses 1 cycle after a reservation to an already-busy register

Behaviour:
- Reset (reset=1 at clk edge):
  - registers load the RESET_MODE values;
  - all busy bits clear;
  - pend_cnt=0, rsv_err=0.
  - Reset overrides any concurrent wr_en or rsv_en.
- Write: on edge with wr_en=1, REG[wr_addr] <= wr_data and busy[wr_addr] clears. If ZERO_REG and wr_addr==0, the write is dropped.
- Read, combinational, per port k:
  - if ZERO_REG and rd_addr_k==0: 0;
  - else if BYPASS and wr_en and wr_addr==rd_addr_k: wr_data;
  - else REG[rd_addr_k].
  - With BYPASS=0, the written value is visible the cycle after the edge.
- rd_busy_k, combinational:
  - busy[rd_addr_k], masked to 0 when BYPASS and wr_en and wr_addr==rd_addr_k;
  - always 0 for register 0 when ZERO_REG.
- Reserve: on edge with rsv_en=1, busy[rsv_addr] <= 1. Ignored for register 0 when ZERO_REG.
- Simultaneous rsv_en and wr_en to the same address: reservation wins. The data is written, but the busy bit ends set because a new producer has been issued.
- Reservation to an already-busy register (not cleared by a same-cycle write): busy stays 1, rsv_err=1 for the next cycle only, pend_cnt unchanged.
- pend_cnt: registered and always equal to popcount(busy) after each edge.
  - +1 on reserve of a non-busy register;
  - −1 on write clearing a busy register;
  - net 0 when both happen to different addresses in one cycle, or in the same-address case;
  - never exceeds 2**ADDR_W − ZERO_REG.
- No combinational path from wr_en/rsv_en to pend_cnt or rsv_err.
- Read latency 0 (async); write and reserve latency 1 edge.
- Out-of-range NUM_RD is an elaboration error.

Decomposition:
- Package regfile_pkg:
  - RESET_ZERO / RESET_INDEX constants;
  - max-read-port constant (4);
  - popcount-free counter width function clog2.
- One sub-module, regfile_scoreboard:
  - holds the busy bits, pend_cnt and rsv_err;
  - provides busy-lookup outputs per read port.
- regfile_mp holds the data array, read muxes and bypass, and instantiates the scoreboard.

Test Plan:
- Reset, RESET_MODE=1 → all ports read their index (rd_addr=7 → 7); RESET_MODE=0 → read 0; pend_cnt=0, rd_busy=0.
- wr_en=1, wr_addr=5, wr_data=0xDEADBEEF, rd_addr0=5 in the same cycle → rd_data0=0xDEADBEEF with BYPASS=1; with BYPASS=0 → old value, new value the next cycle.
- Write 0x1234 to reg 0, then read reg 0 on all ports → 0; rsv_en to reg 0 → rd_busy=0, pend_cnt stays 0.
- Reserve reg 9 → next cycle rd_busy=1 and pend_cnt=1.
  - Write reg 9: rd_busy=0 in the write cycle; next cycle busy=0 and pend_cnt=0.
- Same edge: reserve reg 3 and write reg 3 (busy) with 0xAA → REG[3]=0xAA, busy[3]=1, pend_cnt unchanged, rsv_err=0.
  - A second reserve of reg 3 → rsv_err=1 for exactly one cycle.
- Reserve regs 1..4, then assert reset while wr_en=1 to reg 2 → after the edge, all busy bits are clear, pend_cnt=0 and REG[2] holds its reset value.
